store_buffer: RTL
=================

Name: store_buffer

Overview:
- Write buffer between the EX/MEM pipeline register and data_mem.
- Stores are queued in FIFO order and drained to data_mem one per cycle whenever the memory port is not needed by a load.
- Loads get the port immediately. Loads that hit a buffered store are forwarded from the buffer or stalled.
- All data_mem port signals (rd_en, wr_en, addr, wdata, func3) are driven by this block.

Parameters:
- DEPTH, 4, number of buffered stores; power of two, at least 2.
- AW, 32, address width; matches data_mem addr.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  synchronous reset, active low.
- st_valid  input  1  store request from MEM stage.
- st_addr  input  AW  store address.
- st_wdata  input  32  store data.
- st_func3  input  3  store width (000 SB, 001 SH, 010 SW).
- st_ready  output  1  buffer can accept a store (not full).
- ld_valid  input  1  load request from MEM stage.
- ld_addr  input  AW  load address.
- ld_func3  input  3  load type (000, 001, 010, 100, 101).
- ld_fwd  output  1  load result comes from ld_fwd_data, not data_mem rdata.
- ld_fwd_data  output  32  forwarded load data, extended per ld_func3.
- ld_stall  output  1  load must be held; pipeline freezes the MEM stage.
- drain_req  input  1  fence: keep draining until empty.
- empty  output  1  no entries buffered.
- mem_rd_en  output  1  to data_mem rd_en.
- mem_wr_en  output  1  to data_mem wr_en.
- mem_addr  output  AW  to data_mem addr.
- mem_wdata  output  32  to data_mem wdata.
- mem_func3  output  3  to data_mem func3.

Behaviour:
- Interface (already decided): one clock; reset is synchronous and active-low.
- Reset (rst_n=0 at posedge): head=tail=count=0; all entries invalid; empty=1, st_ready=1, mem_wr_en=0, mem_rd_en=0, ld_fwd=0, ld_stall=0. A reset mid-drain discards all buffered stores.
- Storage: circular FIFO of {addr, wdata, func3}; head and tail are log2(DEPTH) bits with natural wrap; count is log2(DEPTH)+1 bits.
- st_ready = (count != DEPTH), from registered count only.
- Push: st_valid && st_ready writes the entry at tail; tail++ and count++ at the next posedge. A st_valid while full is ignored; the pipeline must stall on st_ready=0.
- Port arbitration (combinational, same cycle), load has priority:
  - ld_valid=1: mem_rd_en=1, mem_addr=ld_addr, mem_func3=ld_func3, mem_wr_en=0; no drain this cycle.
  - else count!=0: mem_wr_en=1, mem_addr/mem_wdata/mem_func3 = head entry; head++ and count-- at the next posedge.
  - else: all mem_* = 0.
- Push and drain in the same cycle: count is unchanged and both pointers advance.
- Load hit check, comparing ld_addr against valid buffered entries only (exact address equality):
  - No match: ld_fwd=0, ld_stall=0; data comes from data_mem.
  - Youngest match has func3=010 (SW) and the load is valid: ld_fwd=1. ld_fwd_data is that entry's wdata with the same extension as data_mem (LB/LH sign-extend bits [7:0]/[15:0]; LW full word; LBU/LHU zero-extend).
  - Any other match: ld_stall=1, ld_fwd=0. mem_rd_en is forced to 0 and the drain proceeds despite ld_valid, until no match remains.
- Simultaneous st_valid and ld_valid: the load checks only pre-existing entries; the store is enqueued normally.
- Drain and empty: empty = (count==0), registered. drain_req does not block pushes; the pipeline holds until empty=1.
- Latency: a store reaches data_mem at the earliest in the cycle after the push; a full buffer empties in DEPTH load-free cycles.

Optional Feature:
- Macro: STBUF_COALESCE_EN.
- Defined: an SW push whose addr equals the youngest valid entry, where that entry is also SW and is not the head being drained this cycle, overwrites that entry's wdata. No allocation; tail and count unchanged; st_ready is unaffected.
- Undefined: every accepted store allocates a new entry.

Test Plan:
- Reset with 3 entries buffered -> count=0, empty=1, mem_wr_en=0, and no stale write reaches data_mem afterwards.
- SW 0x11223344 @5, then 3 idle cycles -> mem_wr_en=1 with addr=5 one cycle after the push; then empty=1; LW @5 reads 0x11223344.
- Fill with 4 SW @1..4 while ld_valid holds the port -> st_ready=0 and a 5th store is ignored; release the port -> 4 drains in FIFO order 1,2,3,4.
- SW 0x000000F0 @7 buffered, then LB @7 -> ld_fwd=1, ld_fwd_data=0xFFFFFFF0; LBU @7 -> 0x000000F0.
- SB 0xAB @9 buffered, then LW @9 -> ld_stall=1 until the entry drains; then ld_fwd=0 and data comes from data_mem.
- With STBUF_COALESCE_EN: SW 0x1 @6 then SW 0x2 @6 with the port blocked -> count=1, and the single drain writes 0x2.

Source files
------------

// File: rtl/store_buffer.sv
// ============================================================================
// Module      : store_buffer
// Description : FIFO write buffer between EX/MEM and data_mem. Loads get
//               the port first, and a load that hits a buffered store is
//               forwarded from it or stalled. Optional macro
//               STBUF_COALESCE_EN merges back-to-back SW pushes to the same
//               address into the youngest entry.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          st_valid_i,
    input  logic [AW-1:0] st_addr_i,
    input  logic [31:0]   st_wdata_i,
    input  logic [2:0]    st_func3_i,
    output logic          st_ready_o,
    input  logic          ld_valid_i,
    input  logic [AW-1:0] ld_addr_i,
    input  logic [2:0]    ld_func3_i,
    output logic          ld_fwd_o,
    output logic [31:0]   ld_fwd_data_o,
    output logic          ld_stall_o,
    input  logic          drain_req_i,
    output logic          empty_o,
    output logic          mem_rd_en_o,
    output logic          mem_wr_en_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [31:0]   mem_wdata_o,
    output logic [2:0]    mem_func3_o
);

    localparam int         c_PW    = $clog2(DEPTH);
    localparam logic [2:0] c_F3_SW = 3'b010;

    logic [AW-1:0]   addr_q [DEPTH];
    logic [31:0]     data_q [DEPTH];
    logic [2:0]      f3_q   [DEPTH];
    logic [c_PW-1:0] head_q, tail_q;
    logic [c_PW:0]   count_q, count_d;
    logic            empty_q;

    logic [c_PW-1:0] w_slot [DEPTH];
    logic            w_hit, w_hit_sw, w_port_ld, w_drain, w_push, w_coal, w_alloc;
    logic [c_PW-1:0] w_hit_idx;
    logic [31:0]     w_hit_data;
    logic            w_unused_drain_req;

    // Pipeline holds on empty_o during a fence; draining runs regardless.
    assign w_unused_drain_req = drain_req_i;

    for (genvar k = 0; k < DEPTH; k++) begin : g_slot
        assign w_slot[k] = head_q + c_PW'(k);
    end

    // Scan oldest to youngest so the last match is the youngest one.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (((c_PW+1)'(k) < count_q) && (addr_q[w_slot[k]] == ld_addr_i)) begin
                w_hit     = 1'b1;
                w_hit_idx = w_slot[k];
            end
        end
    end

    assign w_hit_sw   = (f3_q[w_hit_idx] == c_F3_SW);
    assign w_hit_data = data_q[w_hit_idx];
    assign ld_fwd_o   = ld_valid_i && w_hit && w_hit_sw;
    assign ld_stall_o = ld_valid_i && w_hit && !w_hit_sw;

    always_comb begin
        case (ld_func3_i)
            3'b000:  ld_fwd_data_o = {{24{w_hit_data[7]}}, w_hit_data[7:0]};
            3'b001:  ld_fwd_data_o = {{16{w_hit_data[15]}}, w_hit_data[15:0]};
            3'b100:  ld_fwd_data_o = {24'd0, w_hit_data[7:0]};
            3'b101:  ld_fwd_data_o = {16'd0, w_hit_data[15:0]};
            default: ld_fwd_data_o = w_hit_data;
        endcase
    end

    // A stalled load releases the port so the blocking entry can drain.
    assign w_port_ld = ld_valid_i && !ld_stall_o;
    assign w_drain   = !w_port_ld && (count_q != '0);

    always_comb begin
        mem_rd_en_o = 1'b0;
        mem_wr_en_o = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_func3_o = '0;
        if (w_port_ld) begin
            mem_rd_en_o = 1'b1;
            mem_addr_o  = ld_addr_i;
            mem_func3_o = ld_func3_i;
        end else if (w_drain) begin
            mem_wr_en_o = 1'b1;
            mem_addr_o  = addr_q[head_q];
            mem_wdata_o = data_q[head_q];
            mem_func3_o = f3_q[head_q];
        end
    end

    assign st_ready_o = (count_q != (c_PW+1)'(DEPTH));
    assign empty_o    = empty_q;
    assign w_push     = st_valid_i && st_ready_o;

`ifdef STBUF_COALESCE_EN
    logic [c_PW-1:0] w_last;
    assign w_last = tail_q - c_PW'(1);
    assign w_coal = w_push && (st_func3_i == c_F3_SW) && (count_q != '0)
                    && (addr_q[w_last] == st_addr_i) && (f3_q[w_last] == c_F3_SW)
                    && !(w_drain && (count_q == (c_PW+1)'(1)));
`else
    assign w_coal = 1'b0;
`endif

    assign w_alloc = w_push && !w_coal;

    always_comb begin
        count_d = count_q;
        case ({w_alloc, w_drain})
            2'b10:   count_d = count_q + (c_PW+1)'(1);
            2'b01:   count_d = count_q - (c_PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
        end else begin
            if (w_drain) head_q <= head_q + c_PW'(1);
            if (w_alloc) tail_q <= tail_q + c_PW'(1);
            count_q <= count_d;
            empty_q <= (count_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (w_alloc) begin
            addr_q[tail_q] <= st_addr_i;
            data_q[tail_q] <= st_wdata_i;
            f3_q[tail_q]   <= st_func3_i;
        end
`ifdef STBUF_COALESCE_EN
        if (w_coal) data_q[w_last] <= st_wdata_i;
`endif
    end

endmodule

`default_nettype wire
